// File: rtl/mprj_io_cfg_shifter.sv
// rtl/mprj_io_cfg_shifter.sv - shadow registers and serial daisy-chain loader for the GPIO pad ring.
// Optional MPRJ_CFG_AUTOLOAD_EN: self-start one transfer (D = all ones) right after reset.
module mprj_io_cfg_shifter #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int ADDR_W   = 6,
  parameter int DIV_W    = 4,
  parameter logic [CFG_BITS-1:0] CFG_INIT = 13'h1803
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [CFG_BITS-1:0] cfg_wdata,
  output logic [CFG_BITS-1:0] cfg_rdata,
  output logic                cfg_err,
  input  logic                xfer_start,
  input  logic [DIV_W-1:0]    clk_div,
  output logic                busy,
  output logic                done,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data_out
);

  localparam int NB    = NUM_PADS * CFG_BITS;
  localparam int CNT_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE} state_t;

  state_t                state;
  logic [CFG_BITS-1:0]   shadow [NUM_PADS];
  logic [NB-1:0]         flat;
  logic [CFG_BITS-1:0]   rd_word;
  logic                  addr_ok;
  logic                  we_ok;
  logic [DIV_W-1:0]      div;
  logic [DIV_W-1:0]      ph;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_m1;
  logic                  start;
  logic [DIV_W-1:0]      start_div;
  logic                  first_bit;

  // Pad NUM_PADS-1 occupies the top of the flat vector so shifting from the top gives MSB-first order.
  always_comb begin
    flat    = '0;
    rd_word = '0;
    addr_ok = 1'b0;
    for (int i = 0; i < NUM_PADS; i++) begin
      flat[i*CFG_BITS +: CFG_BITS] = shadow[i];
      if (cfg_addr == ADDR_W'(i)) begin
        rd_word = shadow[i];
        addr_ok = 1'b1;
      end
    end
  end

  assign we_ok  = cfg_we && addr_ok && !busy;
  assign cnt_m1 = cnt - 1'b1;
  // A write landing on the start edge must be the word that ships.
  assign first_bit = (we_ok && cfg_addr == ADDR_W'(NUM_PADS - 1)) ? cfg_wdata[CFG_BITS-1] : flat[NB-1];

`ifdef MPRJ_CFG_AUTOLOAD_EN
  logic auto_pend;
  assign start     = xfer_start || auto_pend;
  assign start_div = auto_pend ? '1 : clk_div;
`else
  assign start     = xfer_start;
  assign start_div = clk_div;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NUM_PADS; i++) shadow[i] <= CFG_INIT;
      cfg_rdata       <= CFG_INIT;
      cfg_err         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      serial_clock    <= 1'b0;
      serial_load     <= 1'b0;
      serial_data_out <= 1'b0;
      state           <= IDLE;
      div             <= '0;
      ph              <= '0;
      cnt             <= '0;
`ifdef MPRJ_CFG_AUTOLOAD_EN
      auto_pend       <= 1'b1;
`endif
    end else begin
`ifdef MPRJ_CFG_AUTOLOAD_EN
      auto_pend <= 1'b0;
`endif
      cfg_err <= cfg_we && (!addr_ok || busy);
      for (int i = 0; i < NUM_PADS; i++)
        if (we_ok && cfg_addr == ADDR_W'(i)) shadow[i] <= cfg_wdata;
      cfg_rdata <= we_ok ? cfg_wdata : rd_word;

      case (state)
        IDLE: begin
          if (start) begin
            state           <= SHIFT_LO;
            div             <= start_div;
            cnt             <= CNT_W'(NB - 1);
            ph              <= '0;
            busy            <= 1'b1;
            serial_clock    <= 1'b0;
            serial_data_out <= first_bit;
          end
        end
        SHIFT_LO: begin
          if (ph == div) begin
            ph           <= '0;
            serial_clock <= 1'b1;
            state        <= SHIFT_HI;
          end else ph <= ph + 1'b1;
        end
        SHIFT_HI: begin
          if (ph == div) begin
            ph           <= '0;
            serial_clock <= 1'b0;
            if (cnt == '0) begin
              serial_load     <= 1'b1;
              serial_data_out <= 1'b0;
              state           <= LOAD;
            end else begin
              cnt             <= cnt_m1;
              serial_data_out <= flat[cnt_m1];
              state           <= SHIFT_LO;
            end
          end else ph <= ph + 1'b1;
        end
        LOAD: begin
          if (ph == div) begin
            ph          <= '0;
            serial_load <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else ph <= ph + 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_io_cfg_shifter.sv
// tb/tb_mprj_io_cfg_shifter.sv - randomized self-checking bench for mprj_io_cfg_shifter.
module tb_mprj_io_cfg_shifter;
  localparam int NP = 2;
  localparam int CB = 4;
  localparam int AW = 3;
`ifdef MPRJ_CFG_AUTOLOAD_EN
  localparam int DW = 2;
`else
  localparam int DW = 4;
`endif
  localparam logic [CB-1:0] INIT = 4'hA;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [CB-1:0] cfg_wdata = '0;
  logic [CB-1:0] cfg_rdata;
  logic          cfg_err;
  logic          xfer_start = 1'b0;
  logic [DW-1:0] clk_div = '0;
  logic          busy, done, serial_clock, serial_load, serial_data_out;

  mprj_io_cfg_shifter #(
    .NUM_PADS(NP), .CFG_BITS(CB), .ADDR_W(AW), .DIV_W(DW), .CFG_INIT(INIT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .xfer_start(xfer_start), .clk_div(clk_div), .busy(busy), .done(done),
    .serial_clock(serial_clock), .serial_load(serial_load), .serial_data_out(serial_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [CB-1:0] model [NP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd(input int a, input int exp, input string tag);
    cfg_addr = AW'(a);
    @(negedge clk);
    check(tag, 32'(cfg_rdata), exp);
  endtask

  task automatic wr(input int a, input int d, input bit exp_err);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = CB'(d);
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err", 32'(cfg_err), 32'(exp_err));
    if (!exp_err) model[a] = CB'(d);
  endtask

  // Entered at the first negedge after the start edge; mode 1 adds a mid-transfer
  // clk_div change and a write attempt while busy.
  task automatic watch(input int d, input int mode);
    int exp_lat;
    logic exp_bits[$];
    logic got_bits[$];
    int cyc, hi_run, load_run;
    bit prev, seen_done;
    logic [CB-1:0] old1;
    exp_lat = 2 * (d + 1) * NP * CB + (d + 1);
    cyc = 0; hi_run = 0; load_run = 0; prev = 1'b0; seen_done = 1'b0;
    old1 = model[1];
    for (int p = NP - 1; p >= 0; p--)
      for (int b = CB - 1; b >= 0; b--) exp_bits.push_back(model[p][b]);
    check("busy_start", 32'(busy), 1);
    while (!seen_done && cyc <= exp_lat + 20) begin
      if (serial_clock && !prev) got_bits.push_back(serial_data_out);
      if (serial_clock) hi_run++;
      else if (prev) begin
        check("hi_phase_len", hi_run, d + 1);
        hi_run = 0;
      end
      if (serial_load) load_run++;
      prev = serial_clock;
      if (done) begin
        seen_done = 1'b1;
        check("latency", cyc, exp_lat);
        check("busy_at_done", 32'(busy), 0);
      end
      if (mode == 1 && cyc == 2) begin
        cfg_we = 1'b1; cfg_addr = AW'(1); cfg_wdata = ~old1;
      end
      if (mode == 1 && cyc == 3) begin
        cfg_we = 1'b0;
        check("err_busy_write", 32'(cfg_err), 1);
      end
      if (mode == 1 && cyc == 4) clk_div = '0;
      if (!seen_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("nbits", got_bits.size(), exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
      check($sformatf("bit%0d", i), 32'(got_bits[i]), 32'(exp_bits[i]));
    check("load_len", load_run, d + 1);
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
  endtask

  task automatic start(input int d, input int mode);
    clk_div = DW'(d);
    xfer_start = 1'b1;
    @(negedge clk);
    xfer_start = 1'b0;
    watch(d, mode);
  endtask

  initial begin
    logic [CB-1:0] w;
    int d, loads;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata", 32'(cfg_rdata), 32'(INIT));
    check("rst_busy", 32'(busy), 0);
    check("rst_sclk", 32'(serial_clock), 0);
    check("rst_sload", 32'(serial_load), 0);
    check("rst_sdo", 32'(serial_data_out), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(cfg_err), 0);
    for (int i = 0; i < NP; i++) model[i] = INIT;
    rst = 1'b0;
`ifdef MPRJ_CFG_AUTOLOAD_EN
    @(negedge clk);
    watch(3, 0);
`endif
    rd(0, INIT, "rd0_init");
    rd(1, INIT, "rd1_init");

    wr(0, 4'h3, 1'b0);
    wr(1, 4'hC, 1'b0);
    rd(0, 4'h3, "rd0_w");
    rd(1, 4'hC, "rd1_w");
    start(0, 0);
    start(2, 1);
    rd(1, model[1], "rd1_after_busy_wr");

    wr(5, 4'h7, 1'b1);
    rd(5, 0, "rd5_oob");

    w = CB'($urandom_range(0, 15));
    clk_div = '0;
    cfg_we = 1'b1; cfg_addr = AW'(1); cfg_wdata = w; xfer_start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; xfer_start = 1'b0;
    check("err_simul", 32'(cfg_err), 0);
    model[1] = w;
    watch(0, 0);

    for (int k = 0; k < 4; k++) begin
      wr(0, $urandom_range(0, 15), 1'b0);
      wr(1, $urandom_range(0, 15), 1'b0);
      d = $urandom_range(0, 3);
      start(d, 0);
    end

    clk_div = DW'(1);
    xfer_start = 1'b1;
    @(negedge clk);
    xfer_start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_sclk", 32'(serial_clock), 0);
    check("midrst_sload", 32'(serial_load), 0);
    rst = 1'b0;
    for (int i = 0; i < NP; i++) model[i] = INIT;
`ifdef MPRJ_CFG_AUTOLOAD_EN
    @(negedge clk);
    watch(3, 0);
`else
    loads = 0;
    repeat (40) begin
      @(negedge clk);
      if (serial_load) loads++;
    end
    check("midrst_no_load", loads, 0);
`endif
    rd(0, INIT, "midrst_rd0");
    rd(1, INIT, "midrst_rd1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
